// File: rtl/fft_acc_ctrl_pkg.sv
// rtl/fft_acc_ctrl_pkg.sv - shared types for the FFT butterfly sequencer
package fft_acc_ctrl_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] top;
    logic [IDX_W-1:0] bot;
  } wb_entry_t;

  function automatic int stage_period(input int log2n, input int bfly_lat);
    return (1 << log2n) + bfly_lat;
  endfunction

endpackage

// File: rtl/fft_acc_bfly_addr_gen.sv
// rtl/fft_acc_bfly_addr_gen.sv - maps (stage, butterfly) to operand indices and twiddle
module fft_acc_bfly_addr_gen #(
  parameter int LOG2N = 10
) (
  input  logic [3:0]       s,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] top,
  output logic [LOG2N-1:0] bot,
  output logic [LOG2N-2:0] tw_idx
);
  localparam int KW = LOG2N - 1;

  logic [LOG2N-1:0] kx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] j;

  always_comb begin
    kx     = {1'b0, k};
    half   = {{(LOG2N-1){1'b0}}, 1'b1} << s;
    j      = kx & (half - {{(LOG2N-1){1'b0}}, 1'b1});
    // Insert a zero at bit s of k to get the top index of the pair.
    top    = ((kx >> s) << (s + 4'd1)) | j;
    bot    = top | half;
    tw_idx = KW'(j << (4'(KW) - s));
  end

endmodule

// File: rtl/fft_acc_bfly_sequencer.sv
// rtl/fft_acc_bfly_sequencer.sv - in-place radix-2 DIT FFT pass sequencer over dual-port RAM
module fft_acc_bfly_sequencer
  import fft_acc_ctrl_pkg::*;
#(
  parameter int LOG2N    = 10,
  parameter int BFLY_LAT = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic [ADDR_W-1:0] a_address,
  output logic [ADDR_W-1:0] b_address,
  output logic              a_write,
  output logic              b_write,
  output logic              ram_clken,
  output logic              bf_in_valid,
  output logic [LOG2N-2:0]  tw_idx
);
  localparam int KW = LOG2N - 1;

  if (BFLY_LAT % 2 != 0) begin : g_lat_chk
    $error("BFLY_LAT must be even");
  end
  if (LOG2N < 2 || LOG2N > 15) begin : g_log2n_chk
    $error("LOG2N must be in 2..15");
  end

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [KW-1:0]     k_q, k_d;
  logic [3:0]        stage_q, stage_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [KW-1:0]     tw_pend_q, tw_pend_d;
  wb_entry_t         wb_q [BFLY_LAT+1];
  wb_entry_t         wb_d [BFLY_LAT+1];
  logic [ADDR_W-1:0] a_address_q, a_address_d;
  logic [ADDR_W-1:0] b_address_q, b_address_d;
  logic              wr_q, wr_d;
  logic              bfv_q, bfv_d;
  logic [KW-1:0]     tw_idx_q, tw_idx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [LOG2N-1:0]  gen_top, gen_bot;
  logic [KW-1:0]     gen_tw;
  logic              issue, tail_wr, pipe_busy;

  fft_acc_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s      (stage_q),
    .k      (k_q),
    .top    (gen_top),
    .bot    (gen_bot),
    .tw_idx (gen_tw)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    k_d         = k_q;
    stage_d     = stage_q;
    base_d      = base_q;
    tw_pend_d   = tw_pend_q;
    a_address_d = a_address_q;
    b_address_d = b_address_q;
    wr_d        = 1'b0;
    bfv_d       = wb_q[0].valid;
    tw_idx_d    = tw_idx_q;
    done_d      = 1'b0;
    issue       = (state_q == ISSUE) && !phase_q;
    tail_wr     = wb_q[BFLY_LAT].valid;
    pipe_busy   = 1'b0;
    wb_d[0]     = '0;
    for (int i = 1; i <= BFLY_LAT; i++) begin
      wb_d[i] = wb_q[i-1];
    end
    for (int i = 0; i < BFLY_LAT; i++) begin
      pipe_busy = pipe_busy | wb_q[i].valid;
    end

    if (wb_q[0].valid) tw_idx_d = tw_pend_q;
    // Writes and reads fall on opposite phases, so they never share an edge.
    if (tail_wr) begin
      wr_d        = 1'b1;
      a_address_d = base_q + ADDR_W'(wb_q[BFLY_LAT].top);
      b_address_d = base_q + ADDR_W'(wb_q[BFLY_LAT].bot);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          base_d  = base_addr;
          stage_d = '0;
          k_d     = '0;
          phase_d = 1'b0;
        end
      end
      ISSUE: begin
        phase_d = ~phase_q;
        if (issue) begin
          wb_d[0]     = '{valid: 1'b1, top: IDX_W'(gen_top), bot: IDX_W'(gen_bot)};
          tw_pend_d   = gen_tw;
          a_address_d = base_q + ADDR_W'(gen_top);
          b_address_d = base_q + ADDR_W'(gen_bot);
          k_d         = k_q + 1'b1;
          if (&k_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        phase_d = ~phase_q;
        if (tail_wr && !pipe_busy) begin
          if (stage_q < 4'(LOG2N - 1)) begin
            state_d = ISSUE;
            stage_d = stage_q + 4'd1;
            k_d     = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      phase_d = 1'b0;
      stage_d = '0;
      k_d     = '0;
      wr_d    = 1'b0;
      bfv_d   = 1'b0;
      done_d  = 1'b0;
      for (int i = 0; i <= BFLY_LAT; i++) begin
        wb_d[i] = '0;
      end
    end

    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      k_q         <= '0;
      stage_q     <= '0;
      base_q      <= '0;
      tw_pend_q   <= '0;
      a_address_q <= '0;
      b_address_q <= '0;
      wr_q        <= 1'b0;
      bfv_q       <= 1'b0;
      tw_idx_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i <= BFLY_LAT; i++) begin
        wb_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      base_q      <= base_d;
      tw_pend_q   <= tw_pend_d;
      a_address_q <= a_address_d;
      b_address_q <= b_address_d;
      wr_q        <= wr_d;
      bfv_q       <= bfv_d;
      tw_idx_q    <= tw_idx_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      for (int i = 0; i <= BFLY_LAT; i++) begin
        wb_q[i] <= wb_d[i];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stage       = stage_q;
  assign a_address   = a_address_q;
  assign b_address   = b_address_q;
  assign a_write     = wr_q;
  assign b_write     = wr_q;
  assign ram_clken   = busy_q;
  assign bf_in_valid = bfv_q;
  assign tw_idx      = tw_idx_q;

endmodule

// File: tb/tb_fft_acc_bfly_sequencer.sv
// tb/tb_fft_acc_bfly_sequencer.sv - self-checking bench for the FFT butterfly sequencer
module tb_fft_acc_bfly_sequencer;
  localparam int LOG2N    = 3;
  localparam int BFLY_LAT = 4;
  localparam int ADDR_W   = 16;
  localparam int NPTS     = 1 << LOG2N;
  localparam int MAXC     = 64;
  localparam int FULL     = LOG2N * (NPTS + BFLY_LAT) + 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, done, a_write, b_write, ram_clken, bf_in_valid;
  logic [3:0]        stage;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [LOG2N-2:0]  tw_idx;

  int checks = 0;
  int errors = 0;

  logic        m_rd   [MAXC];
  logic        m_wr   [MAXC];
  logic        m_bfv  [MAXC];
  logic        m_busy [MAXC];
  logic        m_done [MAXC];
  logic [15:0] m_a    [MAXC];
  logic [15:0] m_b    [MAXC];
  int          m_tw   [MAXC];
  int          m_stage[MAXC];

  fft_acc_bfly_sequencer #(
    .LOG2N   (LOG2N),
    .BFLY_LAT(BFLY_LAT),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .stage      (stage),
    .a_address  (a_address),
    .b_address  (b_address),
    .a_write    (a_write),
    .b_write    (b_write),
    .ram_clken  (ram_clken),
    .bf_in_valid(bf_in_valid),
    .tw_idx     (tw_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pairs are enumerated as every index with bit s clear, in ascending order.
  task automatic build_model(input logic [15:0] base, input int abort_at);
    for (int c = 0; c < MAXC; c++) begin
      m_rd[c] = 0; m_wr[c] = 0; m_bfv[c] = 0; m_busy[c] = 0; m_done[c] = 0;
      m_a[c] = '0; m_b[c] = '0; m_tw[c] = 0; m_stage[c] = 0;
    end
    for (int s = 0; s < LOG2N; s++) begin
      int half;
      int n;
      half = 1 << s;
      n    = 0;
      for (int i = 0; i < NPTS; i++) begin
        if ((i & half) == 0) begin
          int t;
          t = 1 + s * (NPTS + BFLY_LAT) + 2 * n;
          m_rd[t] = 1; m_stage[t] = s;
          m_a[t] = base + 16'(i); m_b[t] = base + 16'(i + half);
          m_bfv[t+1] = 1;
          m_tw[t+1]  = (i % half) * (NPTS / (2 * half));
          m_wr[t+1+BFLY_LAT] = 1;
          m_a[t+1+BFLY_LAT]  = m_a[t];
          m_b[t+1+BFLY_LAT]  = m_b[t];
          n++;
        end
      end
    end
    m_done[LOG2N * (NPTS + BFLY_LAT) + 1] = 1;
    for (int c = 0; c <= LOG2N * (NPTS + BFLY_LAT) + 1; c++) m_busy[c] = 1;
    if (abort_at >= 0) begin
      for (int c = abort_at + 1; c < MAXC; c++) begin
        m_rd[c] = 0; m_wr[c] = 0; m_bfv[c] = 0; m_busy[c] = 0; m_done[c] = 0;
      end
    end
  endtask

  task automatic check_cycle(input int c);
    chk($sformatf("busy@%0d", c), 32'(busy), 32'(m_busy[c]));
    chk($sformatf("clken@%0d", c), 32'(ram_clken), 32'(m_busy[c]));
    chk($sformatf("done@%0d", c), 32'(done), 32'(m_done[c]));
    chk($sformatf("bfv@%0d", c), 32'(bf_in_valid), 32'(m_bfv[c]));
    chk($sformatf("a_wr@%0d", c), 32'(a_write), 32'(m_wr[c]));
    chk($sformatf("b_wr@%0d", c), 32'(b_write), 32'(m_wr[c]));
    if (m_bfv[c]) chk($sformatf("tw@%0d", c), 32'(tw_idx), 32'(m_tw[c]));
    if (m_rd[c] || m_wr[c]) begin
      chk($sformatf("a_addr@%0d", c), 32'(a_address), 32'(m_a[c]));
      chk($sformatf("b_addr@%0d", c), 32'(b_address), 32'(m_b[c]));
    end
    if (m_rd[c]) chk($sformatf("stage@%0d", c), 32'(stage), 32'(m_stage[c]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_a_wr"}, 32'(a_write), 32'd0);
    chk({tag, "_b_wr"}, 32'(b_write), 32'd0);
    chk({tag, "_bfv"}, 32'(bf_in_valid), 32'd0);
    chk({tag, "_clken"}, 32'(ram_clken), 32'd0);
    chk({tag, "_a_addr"}, 32'(a_address), 32'd0);
    chk({tag, "_b_addr"}, 32'(b_address), 32'd0);
    chk({tag, "_tw"}, 32'(tw_idx), 32'd0);
  endtask

  // Start is accepted at the edge after the first negedge; cycle 0 follows it.
  task automatic run_check(input logic [15:0] base, input int abort_at,
                           input int ex1, input int ex2, input int ncyc);
    build_model(base, abort_at);
    @(negedge clk);
    start     = 1'b1;
    abort     = 1'b0;
    base_addr = base;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_cycle(c);
      start     = (c == ex1) || (c == ex2);
      abort     = (c == abort_at);
      base_addr = 16'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run_check(16'h0000, -1, -1, -1, FULL);
    run_check(16'hFFFC, -1, -1, -1, FULL);
    for (int r = 0; r < 2; r++) begin
      run_check(16'($urandom), -1, -1, -1, FULL);
    end

    run_check(16'($urandom), 15, -1, -1, 22);
    run_check(16'($urandom), int'($urandom_range(2, 34)), -1, -1, 40);
    run_check(16'($urandom), -1, -1, -1, FULL);

    run_check(16'h0100, -1, 5, 36, FULL);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("sa_busy@%0d", c), 32'(busy), 32'd0);
      chk($sformatf("sa_bfv@%0d", c), 32'(bf_in_valid), 32'd0);
      chk($sformatf("sa_wr@%0d", c), 32'(a_write), 32'd0);
    end

    run_check(16'($urandom), -1, -1, -1, 10);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    run_check(16'($urandom), -1, -1, -1, FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
